// File: rtl/uart_rx.sv
// 8N1 serial receiver: the start edge re-aligns a bit-period counter, and every
// bit is sampled at its centre through a two-flop synchronizer.
module uart_rx #(
   parameter int unsigned CLK_DIV = 10416
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic        sync1_r, sync2_r, rx_s;
   state_t      state_r, state_s;
   logic [15:0] cnt_r, cnt_s;
   logic [2:0]  idx_r, idx_s;
   logic [7:0]  shift_r, shift_s;
   logic [7:0]  data_r, data_s;
   logic        valid_r, valid_s;
   logic        ferr_r, ferr_s;
   logic        busy_r;

   assign rx_s = sync2_r;

   // Synchronize the asynchronous serial line; idle level is 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rxd;
         sync2_r <= sync1_r;
      end
   end

   // Next-state, bit timing and output strobe decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      data_s  = data_r;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!rx_s) begin
               state_s = S_START;
               cnt_s   = 16'd0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_r == HALF_M1) begin
               cnt_s = 16'd0;
               idx_s = 3'd0;
               if (!rx_s) begin
                  state_s = S_DATA;
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_r == DIV_M1) begin
               cnt_s   = 16'd0;
               // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
               shift_s = {rx_s, shift_r[7:1]};
               if (idx_r == 3'd7) begin
                  state_s = S_STOP;
               end else begin
                  idx_s = idx_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_r == DIV_M1) begin
               cnt_s = 16'd0;
               if (rx_s) begin
                  data_s  = shift_r;
                  valid_s = 1'b1;
                  state_s = S_IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = S_BREAK;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         S_BREAK: begin
            // A line held low must return high before a new start is accepted.
            if (rx_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_BREAK;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Receiver state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
         cnt_r   <= 16'd0;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         ferr_r  <= ferr_s;
         busy_r  <= (state_s != S_IDLE);
      end
   end

   assign data      = data_r;
   assign valid     = valid_r;
   assign frame_err = ferr_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences and randomized frames, on CLK_DIV=16 and CLK_DIV=5 instances.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd16 = 1'b1;
   logic       rxd5 = 1'b1;
   logic [7:0] data16, data5;
   logic       valid16, valid5, ferr16, ferr5, busy16, busy5;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int         t;
      logic [7:0] d;
   } ev_t;

   typedef struct {
      bit         sel5;
      logic [7:0] d;
      logic       stop;
      int         gap;
      logic       exp_v;
      logic       exp_e;
      logic [7:0] exp_d;
   } vec_t;

   ev_t vq16[$], vq5[$];
   int  eq16[$], eq5[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.CLK_DIV(16)) dut16 (
      .clk(clk), .rst(rst), .rxd(rxd16), .data(data16),
      .valid(valid16), .frame_err(ferr16), .busy(busy16)
   );

   uart_rx #(.CLK_DIV(5)) dut5 (
      .clk(clk), .rst(rst), .rxd(rxd5), .data(data5),
      .valid(valid5), .frame_err(ferr5), .busy(busy5)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Record every output pulse with its cycle number.
   always @(negedge clk) begin
      if (valid16) vq16.push_back('{cyc, data16});
      if (ferr16) eq16.push_back(cyc);
      if (valid5) vq5.push_back('{cyc, data5});
      if (ferr5) eq5.push_back(cyc);
      if (valid16 || ferr16) check("excl16", 32'(valid16 & ferr16), 32'd0);
      if (valid5 || ferr5) check("excl5", 32'(valid5 & ferr5), 32'd0);
   end

   // Reference latency: E0 is the edge after the start bit is driven, the stop
   // sample is at E(2+H+9*D), and the pulse is seen in the following cycle.
   function automatic int lat(input int dv);
      return 3 + dv / 2 + 9 * dv;
   endfunction

   task automatic line(input bit sel5, input logic v, input int n);
      if (sel5) rxd5 = v;
      else rxd16 = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input bit sel5, input logic [7:0] d, input logic stop, output int t0);
      int dv;
      logic [9:0] fr;
      dv = sel5 ? 5 : 16;
      fr = {stop, d, 1'b0};
      t0 = cyc;
      for (int k = 0; k < 10; k++) line(sel5, fr[k], dv);
   endtask

   task automatic check_frame(input bit sel5, input int t0, input logic exp_v,
                              input logic exp_e, input logic [7:0] exp_d, output int vt);
      ev_t vq[$];
      int  eq[$];
      logic [7:0] dd;
      logic bz;
      int dv;
      #1;
      dv = sel5 ? 5 : 16;
      if (sel5) begin
         vq = vq5; eq = eq5; vq5.delete(); eq5.delete(); dd = data5; bz = busy5;
      end else begin
         vq = vq16; eq = eq16; vq16.delete(); eq16.delete(); dd = data16; bz = busy16;
      end
      vt = -1;
      check("valid_count", 32'(vq.size()), 32'(exp_v));
      if (exp_v && vq.size() == 1) begin
         vt = vq[0].t;
         check("valid_time", 32'(vq[0].t - t0), 32'(lat(dv)));
         check("valid_data", 32'(vq[0].d), 32'(exp_d));
      end
      check("ferr_count", 32'(eq.size()), 32'(exp_e));
      if (exp_e && eq.size() == 1) check("ferr_time", 32'(eq[0] - t0), 32'(lat(dv)));
      check("data_hold", 32'(dd), 32'(exp_d));
      check("busy_at_stop_end", 32'(bz), 32'(exp_e));
   endtask

   initial begin
      vec_t tbl[$];
      int t0, vt, prev_vt, prev_gap, nb, first;
      logic [9:0] fr;
      logic [7:0] mdl16, mdl5, rd;
      logic rs;
      bit rsel;
      int rgap;
      logic prev_sel;

      tbl.push_back('{1'b0, 8'h55, 1'b1, 8, 1'b1, 1'b0, 8'h55});
      tbl.push_back('{1'b0, 8'hA3, 1'b0, 8, 1'b0, 1'b1, 8'h55});
      tbl.push_back('{1'b0, 8'h3C, 1'b1, 4, 1'b1, 1'b0, 8'h3C});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00});
      tbl.push_back('{1'b0, 8'hFF, 1'b1, 6, 1'b1, 1'b0, 8'hFF});
      tbl.push_back('{1'b1, 8'h81, 1'b1, 6, 1'b1, 1'b0, 8'h81});
      tbl.push_back('{1'b1, 8'h7E, 1'b0, 6, 1'b0, 1'b1, 8'h81});
      tbl.push_back('{1'b1, 8'h18, 1'b1, 3, 1'b1, 1'b0, 8'h18});

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data16", 32'(data16), 32'h00);
      check("rst_valid16", 32'(valid16), 32'd0);
      check("rst_ferr16", 32'(ferr16), 32'd0);
      check("rst_busy16", 32'(busy16), 32'd0);
      check("rst_busy5", 32'(busy5), 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Directed frame table
      prev_vt = -1;
      prev_gap = -1;
      prev_sel = 1'b0;
      foreach (tbl[i]) begin
         send(tbl[i].sel5, tbl[i].d, tbl[i].stop, t0);
         check_frame(tbl[i].sel5, t0, tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_d, vt);
         if (prev_gap == 0 && prev_vt >= 0 && vt >= 0 && prev_sel == tbl[i].sel5)
            check("b2b_spacing", 32'(vt - prev_vt), 32'(tbl[i].sel5 ? 50 : 160));
         line(tbl[i].sel5, 1'b1, tbl[i].gap);
         if (tbl[i].gap >= 4)
            check("busy_after_gap", 32'(tbl[i].sel5 ? busy5 : busy16), 32'd0);
         prev_vt = vt;
         prev_gap = tbl[i].gap;
         prev_sel = tbl[i].sel5;
      end

      // False start: 4-cycle low glitch
      line(1'b0, 1'b1, 4);
      t0 = cyc;
      nb = 0;
      first = -1;
      for (int i = 0; i < 24; i++) begin
         line(1'b0, (i < 4) ? 1'b0 : 1'b1, 1);
         if (busy16) begin
            nb++;
            if (first < 0) first = cyc - t0;
         end
      end
      #1;
      check("glitch_busy_cycles", 32'(nb), 32'd8);
      check("glitch_busy_first", 32'(first), 32'd3);
      check("glitch_no_valid", 32'(vq16.size()), 32'd0);
      check("glitch_no_ferr", 32'(eq16.size()), 32'd0);
      check("glitch_data", 32'(data16), 32'hFF);

      // Reset during data bit 4
      @(negedge clk);
      fr = {1'b1, 8'h5A, 1'b0};
      for (int k = 0; k < 5; k++) line(1'b0, fr[k], 16);
      line(1'b0, fr[5], 8);
      #2 rst = 1'b0;
      #1;
      check("arst_data16", 32'(data16), 32'h00);
      check("arst_valid16", 32'(valid16), 32'd0);
      check("arst_ferr16", 32'(ferr16), 32'd0);
      check("arst_busy16", 32'(busy16), 32'd0);
      check("arst_data5", 32'(data5), 32'h00);
      rxd16 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_pulse", 32'(vq16.size() + eq16.size()), 32'd0);
      send(1'b0, 8'h3C, 1'b1, t0);
      check_frame(1'b0, t0, 1'b1, 1'b0, 8'h3C, vt);
      line(1'b0, 1'b1, 4);

      // Randomized frames against the frame-level model
      mdl16 = 8'h3C;
      mdl5 = 8'h00;
      for (int n = 0; n < 40; n++) begin
         rsel = 1'($urandom_range(0, 1));
         rd = 8'($urandom);
         rs = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
         rgap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(6, 12));
         fr = {rs, rd, 1'b0};
         if (fr[9]) begin
            if (rsel) mdl5 = fr[8:1];
            else mdl16 = fr[8:1];
         end
         send(rsel, rd, rs, t0);
         check_frame(rsel, t0, fr[9], ~fr[9], rsel ? mdl5 : mdl16, vt);
         line(rsel, 1'b1, rgap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), line idle high. It is the receive-side counterpart of the bit-period tick generator that paces the transmit path. It times bits with an internal clock-divider counter that is re-aligned on every start edge. Received bytes go to the system logic with a one-cycle valid strobe; framing errors are flagged separately.

## Interface
- CLK_DIV, default 10416: clock cycles per bit. Legal range 4..65535. Simulation benches use 16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rxd  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse: data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rxd passes through a 2-flop synchronizer. Both flops reset to 1. The FSM only sees the synchronized output rx_s.
- Counter cnt is 16 bits, unsigned. H = CLK_DIV/2 using integer division. Bit counter idx is 3 bits. Shift register is 8 bits.
- IDLE: if rx_s==0, go to START with cnt<=0.
- START: cnt increments each clock. When cnt==H-1, sample rx_s:
  - rx_s==0: go to DATA with cnt<=0, idx<=0.
  - rx_s==1: false start (glitch); return to IDLE with no output activity.
- DATA: cnt increments each clock. When cnt==CLK_DIV-1:
  - Shift rx_s into the MSB of the shift register (so the LSB-first stream is assembled correctly).
  - Set cnt<=0.
  - If idx==7, go to STOP; otherwise idx<=idx+1.
- STOP: when cnt==CLK_DIV-1, sample rx_s:
  - rx_s==1: data<=shift register, valid<=1, go to IDLE.
  - rx_s==0: frame_err<=1, data unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from being taken as a new start.
- valid and frame_err are registered. Each is high for exactly one cycle and never high in the same cycle as the other.
- Reset (rst low, at any time, including mid-frame): immediately sets state IDLE, cnt=0, idx=0, shift register=0, data=0x00, valid=0, frame_err=0, busy=0, synchronizer flops=1. The frame in progress is discarded with no pulse.

## Timing
- Let E0 be the clock edge that first captures rxd low into sync flop 1.
- rx_s goes low after E1. IDLE detects it at E2.
- Start bit is checked at E(2+H).
- Data bit i is sampled at E(2+H+(i+1)·CLK_DIV).
- Stop bit is sampled at E(2+H+9·CLK_DIV). valid/frame_err are high in the cycle after this edge.
- For CLK_DIV=16 the stop sample is at E154. Because of the 2-cycle synchronizer, this sample reflects rxd at cycle 152, which is the centre of the stop bit.
- busy rises in the cycle after E2 and falls in the same cycle valid rises.
- Back-to-back frames: IDLE is entered in the cycle after the stop sample. A start edge arriving half a bit later is detected normally, so there is no minimum idle gap.
- Clock-to-sample drift is not corrected within a frame. Tolerance is about ±5% of baud over 10 bits.

## Test plan
- 0x55, CLK_DIV=16, exact 16-cycle bits -> data=0x55, single valid pulse at E154 relative to the start edge, frame_err stays 0.
- rxd low for 4 clocks, then high -> START aborts at E10, no valid, no frame_err, busy high for 8 cycles then 0.
- 0x55 good frame, then 0xA3 with stop bit forced 0 -> frame_err pulse, no valid, data stays 0x55. busy stays high until rxd returns high, then a following 0x3C frame is received.
- Frames 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles apart, data 0x00 then 0xFF.
- rst pulsed low during data bit 4 of a frame -> all outputs 0 asynchronously, no pulse. After release with rxd high, next frame 0x3C gives data=0x3C, valid once.
- CLK_DIV=5 (odd, H=2), 5-cycle bits sending 0x81 -> data=0x81, valid pulse, no frame_err.
